swap_sequencer: RTL and testbench
=================================

SWAP_SEQUENCER -- requirements
Module: swap_sequencer

Interface
REQ-001 The block SHALL take parameter DATA_W, default 20, as the register word width.
REQ-002 The block SHALL take parameter ADDR_W, default 4, as the register-file address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1, meaning a swap request is presented.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port req_addr_a, input, ADDR_W, the first register index.
REQ-008 The block SHALL have port req_addr_b, input, ADDR_W, the second register index.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port rf_rd_en, output, 1, the register-file read strobe; data returns one cycle later.
REQ-012 The block SHALL have port rf_wr_en, output, 1, the register-file write strobe.
REQ-013 The block SHALL have port rf_addr, output, ADDR_W, the shared register-file address.
REQ-014 The block SHALL have port rf_wdata, output, DATA_W, the register-file write data.
REQ-015 The block SHALL have port rf_rdata, input, DATA_W, the register-file read data, valid the cycle after rf_rd_en.
REQ-016 The block SHALL have port swap_count, output, 16, the number of completed swaps, saturating.

Function
REQ-017 The block SHALL implement the states IDLE, RD_A, RD_B, CAPT, WR_A, WR_B and DONE.
REQ-018 The block SHALL drive req_ready high only in IDLE; a handshake occurs when req_valid and req_ready are both high.
REQ-019 On a handshake the block SHALL latch both addresses and go to RD_A, or go directly to DONE when addr_a equals addr_b, with no register-file access.
REQ-020 In RD_A the block SHALL assert rf_rd_en with rf_addr=addr_a, then go to RD_B.
REQ-021 In RD_B the block SHALL assert rf_rd_en with rf_addr=addr_b, capture rf_rdata into word_a, then go to CAPT.
REQ-022 In CAPT the block SHALL capture rf_rdata into word_b, then go to WR_A.
REQ-023 The block SHALL pass word_a and word_b through the swap sub-module, whose outputs are word_b and word_a respectively.
REQ-024 In WR_A the block SHALL assert rf_wr_en with rf_addr=addr_a and rf_wdata=word_b; in WR_B it SHALL assert rf_wr_en with rf_addr=addr_b and rf_wdata=word_a.
REQ-025 In DONE the block SHALL pulse done for exactly one cycle, increment swap_count (saturating at 0xFFFF), then return to IDLE.
REQ-026 A distinct-address swap SHALL take 6 cycles from the handshake edge to done; an equal-address swap SHALL take 1 cycle.
REQ-027 The block SHALL never assert rf_rd_en and rf_wr_en in the same cycle, and SHALL drive both low outside their states.
REQ-028 The block SHALL ignore req_valid and input address changes while busy.
REQ-029 In idle cycles the block SHALL drive rf_addr and rf_wdata to zero.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state IDLE, with req_ready=1, busy=0, done=0, rf_rd_en=0, rf_wr_en=0, rf_addr=0, rf_wdata=0, swap_count=0, and the internal words cleared.
REQ-031 A reset during any state, including WR_A, SHALL abort the operation with no further register-file writes; a partial swap is acceptable.

Structure
REQ-032 The state encoding and the default DATA_W and ADDR_W values SHALL reside in the shared CPU package.
REQ-033 The block SHALL instantiate the existing swap datapath module as its single sub-module; there SHALL be no other sub-modules.

Verification
REQ-034 Regfile model with R3=0x12345 and R9=0xABCDE; request (3,9) -> done 6 cycles after the handshake, R3=0xABCDE, R9=0x12345, swap_count=1.
REQ-035 Request (5,5) -> done 1 cycle after the handshake, no rf_rd_en or rf_wr_en pulse, swap_count increments.
REQ-036 req_valid held high with a new request (1,2) during busy -> the request is not accepted until the cycle after done; back-to-back swaps complete correctly.
REQ-037 rst_n pulsed low during WR_A -> all outputs go to reset values asynchronously, no WR_B write occurs, swap_count=0.
REQ-038 swap_count preloaded by issuing 65536 equal-address swaps -> swap_count holds at 0xFFFF.
REQ-039 Random addresses and data over 200 requests -> each swap matches the scoreboard, and no cycle has both rf_rd_en and rf_wr_en high.

Source files
------------

// File: rtl/swap_sequencer_pkg.sv
// Shared definitions for the swap sequencer: default widths, FSM encoding,
// and the saturating completion-counter helper.
package swap_sequencer_pkg;

    localparam int DEF_DATA_W = 20;
    localparam int DEF_ADDR_W = 4;
    localparam int COUNT_W    = 16;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_CAPT = 3'd3,
        ST_WR_A = 3'd4,
        ST_WR_B = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == COUNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/swap_sequencer_swap.sv
// Swap datapath: presents the two captured words in exchanged order so the
// sequencer can write each one back to the other register.
module swap_sequencer_swap
    import swap_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] word_a,
    input  logic [DATA_W-1:0] word_b,
    output logic [DATA_W-1:0] swapped_a,
    output logic [DATA_W-1:0] swapped_b
);

    // Bitwise cross-connection: swapped_a carries word_b, swapped_b carries word_a.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
        assign swapped_a[gi] = word_b[gi];
        assign swapped_b[gi] = word_a[gi];
    end

endmodule

// File: rtl/swap_sequencer.sv
// Swap sequencer: on request, reads two registers through a shared
// register-file port, then writes them back exchanged. Equal addresses
// complete immediately without touching the register file.
module swap_sequencer
    import swap_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    output logic              done,
    output logic              busy,
    output logic              rf_rd_en,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [15:0]       swap_count
);

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_a_reg;
    logic [ADDR_W-1:0]   addr_b_reg;
    logic [DATA_W-1:0]   word_a_reg;
    logic [DATA_W-1:0]   word_b_reg;
    logic [COUNT_W-1:0]  count_reg;
    logic [DATA_W-1:0]   swapped_a;
    logic [DATA_W-1:0]   swapped_b;

    swap_sequencer_swap #(
        .DATA_W (DATA_W)
    ) u_swap (
        .word_a    (word_a_reg),
        .word_b    (word_b_reg),
        .swapped_a (swapped_a),
        .swapped_b (swapped_b)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Address latch on handshake, word capture from the registered read
    // port, and the saturating completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            word_a_reg <= '0;
            word_b_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (state_reg == ST_IDLE && req_valid) begin
                addr_a_reg <= req_addr_a;
                addr_b_reg <= req_addr_b;
            end
            // Read data lags the strobe by one cycle, so word_a arrives
            // during RD_B and word_b during CAPT.
            if (state_reg == ST_RD_B) begin
                word_a_reg <= rf_rdata;
            end
            if (state_reg == ST_CAPT) begin
                word_b_reg <= rf_rdata;
            end
            if (state_reg == ST_DONE) begin
                count_reg <= sat_inc(count_reg);
            end
        end
    end

    // Next-state and Moore outputs; register-file port idles at zero.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        rf_rd_en   = 1'b0;
        rf_wr_en   = 1'b0;
        rf_addr    = '0;
        rf_wdata   = '0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = (req_addr_a == req_addr_b) ? ST_DONE : ST_RD_A;
                end
            end
            ST_RD_A: begin
                rf_rd_en   = 1'b1;
                rf_addr    = addr_a_reg;
                state_next = ST_RD_B;
            end
            ST_RD_B: begin
                rf_rd_en   = 1'b1;
                rf_addr    = addr_b_reg;
                state_next = ST_CAPT;
            end
            ST_CAPT: begin
                state_next = ST_WR_A;
            end
            ST_WR_A: begin
                rf_wr_en   = 1'b1;
                rf_addr    = addr_a_reg;
                rf_wdata   = swapped_a;
                state_next = ST_WR_B;
            end
            ST_WR_B: begin
                rf_wr_en   = 1'b1;
                rf_addr    = addr_b_reg;
                rf_wdata   = swapped_b;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign swap_count = count_reg;

endmodule

// File: tb/tb_swap_sequencer.sv
// Testbench for swap_sequencer: a register-file environment, a timeline-based
// reference model, a per-cycle compare process, directed cases and random swaps.
module tb_swap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_addr_a = '0;
    logic [3:0]  req_addr_b = '0;
    logic        done;
    logic        busy;
    logic        rf_rd_en;
    logic        rf_wr_en;
    logic [3:0]  rf_addr;
    logic [19:0] rf_wdata;
    logic [19:0] rf_rdata = '0;
    logic [15:0] swap_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    swap_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .done       (done),
        .busy       (busy),
        .rf_rd_en   (rf_rd_en),
        .rf_wr_en   (rf_wr_en),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .rf_rdata   (rf_rdata),
        .swap_count (swap_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file environment: registered read, synchronous write, bench loads.
    logic [19:0] mem [16];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [19:0] ld_data = '0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (rf_rd_en) begin
            rf_rdata  <= mem[rf_addr];
            rd_pulses <= rd_pulses + 1;
        end
        if (rf_wr_en) begin
            mem[rf_addr] <= rf_wdata;
            wr_pulses    <= wr_pulses + 1;
        end
    end

    // Reference model: phase = cycles since handshake (0 = idle). A distinct
    // swap reads in phases 1-2, writes in 4-5 and completes in 6; an
    // equal-address swap completes in phase 1. Memory is swapped on completion.
    int          phase = 0;
    logic        m_eq = 1'b0;
    logic [3:0]  m_a = '0;
    logic [3:0]  m_b = '0;
    logic [19:0] m_va = '0;
    logic [19:0] m_vb = '0;
    logic [15:0] m_count = '0;
    logic [19:0] ref_mem [16];

    always @(posedge clk or negedge rst_n) begin
        if (ld_en) ref_mem[ld_addr] <= ld_data;
        if (!rst_n) begin
            phase   <= 0;
            m_count <= '0;
        end else if (phase == 0) begin
            if (req_valid) begin
                m_a   <= req_addr_a;
                m_b   <= req_addr_b;
                m_va  <= ref_mem[req_addr_a];
                m_vb  <= ref_mem[req_addr_b];
                m_eq  <= (req_addr_a == req_addr_b);
                phase <= 1;
            end
        end else if (phase == (m_eq ? 1 : 6)) begin
            phase   <= 0;
            m_count <= (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
            if (!m_eq) begin
                ref_mem[m_a] <= m_vb;
                ref_mem[m_b] <= m_va;
            end
        end else begin
            phase <= phase + 1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : cmp
        logic        e_done, e_rd, e_wr;
        logic [3:0]  e_addr;
        logic [19:0] e_wdata;
        e_done  = (phase != 0) && (phase == (m_eq ? 1 : 6));
        e_rd    = !m_eq && (phase == 1 || phase == 2);
        e_wr    = !m_eq && (phase == 4 || phase == 5);
        e_addr  = (!m_eq && (phase == 1 || phase == 4)) ? m_a :
                  (!m_eq && (phase == 2 || phase == 5)) ? m_b : 4'd0;
        e_wdata = (!m_eq && phase == 4) ? m_vb :
                  (!m_eq && phase == 5) ? m_va : 20'd0;
        chk("req_ready", 32'(req_ready), 32'(phase == 0));
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("done", 32'(done), 32'(e_done));
        chk("rf_rd_en", 32'(rf_rd_en), 32'(e_rd));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(e_wr));
        chk("rd_wr_overlap", 32'(rf_rd_en & rf_wr_en), 32'd0);
        chk("swap_count", 32'(swap_count), 32'(m_count));
        if (e_rd || e_wr || phase == 0) chk("rf_addr", 32'(rf_addr), 32'(e_addr));
        if (e_wr || phase == 0) chk("rf_wdata", 32'(rf_wdata), 32'(e_wdata));
        if (e_done && !m_eq) begin
            chk("mem_a_after_swap", 32'(mem[m_a]), 32'(m_vb));
            chk("mem_b_after_swap", 32'(mem[m_b]), 32'(m_va));
        end
    end

    task automatic load(input logic [3:0] a, input logic [19:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Present a request and return just after its handshake edge; req_valid stays high.
    task automatic start_req(input logic [3:0] a, input logic [3:0] b);
        int guard;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr_a = a; req_addr_b = b;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready && guard < 50);
        if (!req_ready) chk("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    // Count cycles from the handshake edge to the done pulse; drops req_valid there.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin : stim
        int lat, rd0, wr0, guard;
        logic [19:0] o1, o2, o3, o4, o7, o9;
        logic [3:0]  a, b;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(swap_count), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) load(4'(i), 20'($urandom));

        // Directed swap (3,9)
        load(4'd3, 20'h12345);
        load(4'd9, 20'hABCDE);
        start_req(4'd3, 4'd9);
        req_valid = 1'b0;
        wait_done(lat);
        $display("swap (3,9): latency %0d", lat);
        chk("lat_3_9", 32'(lat), 32'd6);
        chk("r3_swapped", 32'(mem[3]), 32'h000ABCDE);
        chk("r9_swapped", 32'(mem[9]), 32'h00012345);
        @(posedge clk); #1;
        chk("count_after_first", 32'(swap_count), 32'd1);

        // Equal-address swap (5,5): no register-file traffic
        rd0 = rd_pulses; wr0 = wr_pulses;
        start_req(4'd5, 4'd5);
        req_valid = 1'b0;
        wait_done(lat);
        $display("swap (5,5): latency %0d", lat);
        chk("lat_5_5", 32'(lat), 32'd1);
        @(posedge clk); #1;
        chk("rd_pulses_5_5", 32'(rd_pulses - rd0), 32'd0);
        chk("wr_pulses_5_5", 32'(wr_pulses - wr0), 32'd0);
        chk("count_after_equal", 32'(swap_count), 32'd2);

        // Back-to-back: new request (1,2) held while busy with (4,7)
        o1 = mem[1]; o2 = mem[2]; o4 = mem[4]; o7 = mem[7];
        start_req(4'd4, 4'd7);
        req_addr_a = 4'd1; req_addr_b = 4'd2;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        $display("swap (4,7): latency %0d", lat);
        chk("lat_4_7", 32'(lat), 32'd6);
        chk("ready_during_done", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_done", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(lat);
        $display("swap (1,2): latency %0d", lat);
        chk("lat_1_2", 32'(lat), 32'd6);
        chk("r4_swapped", 32'(mem[4]), 32'(o7));
        chk("r7_swapped", 32'(mem[7]), 32'(o4));
        chk("r1_swapped", 32'(mem[1]), 32'(o2));
        chk("r2_swapped", 32'(mem[2]), 32'(o1));
        @(posedge clk); #1;
        chk("count_after_b2b", 32'(swap_count), 32'd4);

        // Reset asserted during WR_A aborts with no further writes
        o3 = mem[3]; o9 = mem[9];
        start_req(4'd3, 4'd9);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("in_wr_a_wr_en", 32'(rf_wr_en), 32'd1);
        chk("in_wr_a_addr", 32'(rf_addr), 32'd3);
        wr0 = wr_pulses;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(req_ready), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_rd_en", 32'(rf_rd_en), 32'd0);
        chk("async_rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("async_rst_addr", 32'(rf_addr), 32'd0);
        chk("async_rst_wdata", 32'(rf_wdata), 32'd0);
        chk("async_rst_count", 32'(swap_count), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_writes", 32'(wr_pulses - wr0), 32'd0);
        chk("abort_r3_kept", 32'(mem[3]), 32'(o3));
        chk("abort_r9_kept", 32'(mem[9]), 32'(o9));
        $display("reset during WR_A: swap_count %0d", swap_count);

        // Random requests, sometimes with stray requests held while busy
        for (int n = 0; n < 200; n++) begin
            a = 4'($urandom);
            b = ($urandom_range(0, 5) == 0) ? a : 4'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            start_req(a, b);
            if ($urandom_range(0, 1) == 1) begin
                req_addr_a = 4'($urandom);
                req_addr_b = 4'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            wait_done(lat);
            $display("random swap %0d: (%0d,%0d) latency %0d", n, a, b, lat);
            chk("random_latency", 32'(lat), (a == b) ? 32'd1 : 32'd6);
        end

        // Saturation: continuous equal-address swaps until the counter tops out
        start_req(4'd0, 4'd0);
        guard = 0;
        while (swap_count != 16'hFFFF && guard < 140000) begin
            @(negedge clk);
            guard++;
        end
        repeat (8) @(negedge clk);
        chk("count_saturated", 32'(swap_count), 32'h0000FFFF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("count_held", 32'(swap_count), 32'h0000FFFF);
        $display("saturation: swap_count 0x%0h", swap_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
